// File: rtl/binary_to_bcd.sv
// Sequential double-dabble converter: one adjust+shift per clock, result and
// overflow flag registered in DONE and announced with a one-cycle o_Done pulse.
module binary_to_bcd #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_n,
    input  logic                  i_Start,
    input  logic [WIDTH-1:0]      i_Binary,
    output logic [4*DIGITS-1:0]   o_BCD,
    output logic                  o_Overflow,
    output logic                  o_Busy,
    output logic                  o_Done
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned BCD_W = 4 * DIGITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [BCD_W-1:0]   adj;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               overflow_q, overflow_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Per-digit +3 correction; digits are independent, no carry between them.
    always_comb begin
        adj = scratch_q;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (scratch_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        scratch_d  = scratch_q;
        ovf_d      = ovf_q;
        cnt_d      = cnt_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_Start) begin
                    bin_d     = i_Binary;
                    scratch_d = '0;
                    ovf_d     = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_CONVERT;
                end
            end
            S_CONVERT: begin
                // Bits pushed out of the top digit mean the value needs more digits.
                scratch_d = {adj[BCD_W-2:0], bin_q[WIDTH-1]};
                ovf_d     = ovf_q | adj[BCD_W-1];
                bin_d     = bin_q << 1;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                bcd_d      = scratch_q;
                overflow_d = ovf_q;
                done_d     = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q    <= S_IDLE;
            bin_q      <= '0;
            scratch_q  <= '0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            scratch_q  <= scratch_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign o_BCD      = bcd_q;
    assign o_Overflow = overflow_q;
    assign o_Busy     = busy_q;
    assign o_Done     = done_q;

endmodule
